debug_frame_collector: RTL and testbench

- Host-side end of the debug control frame link.
- Accepts a controller-ID request from the debug command path and drives the shared request-select bus to that ID.
- Captures the burst of control frames the selected latch controller streams out while its writing flag is high.
- Serializes the captured frames MSB-byte-first to the UART transmitter through a start/done handshake.

---
 rtl/debug_frame_collector_if.sv | 37 +++
 rtl/debug_frame_collector.sv | 177 +++++++++++++++++
 tb/tb_debug_frame_collector.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/debug_frame_collector_if.sv
// Bus bundle between the debug frame collector and its surroundings:
// command-path request handshake, latch-controller select/frame bus,
// UART TX byte handshake and the collector status outputs.
interface debug_frame_collector_if #(
    parameter int NB_CONTROL_FRAME = 32,
    parameter int NB_BYTE          = 8,
    parameter int NB_REQUEST       = 6
);
    logic                        i_request_valid;
    logic [NB_REQUEST-1:0]       i_request_id;
    logic                        o_request_ready;
    logic [NB_REQUEST-1:0]       o_request_select;
    logic [NB_CONTROL_FRAME-1:0] i_frame_from_control;
    logic                        i_writing;
    logic [NB_BYTE-1:0]          o_tx_data;
    logic                        o_tx_start;
    logic                        i_tx_done;
    logic                        o_busy;
    logic                        o_done;
    logic                        o_timeout;
    logic                        o_overflow;
    logic [3:0]                  o_frame_count;

    // Collector side
    modport master (
        input  i_request_valid, i_request_id, i_frame_from_control, i_writing, i_tx_done,
        output o_request_ready, o_request_select, o_tx_data, o_tx_start,
               o_busy, o_done, o_timeout, o_overflow, o_frame_count
    );

    // Environment side (command path, latch controllers, UART TX)
    modport slave (
        output i_request_valid, i_request_id, i_frame_from_control, i_writing, i_tx_done,
        input  o_request_ready, o_request_select, o_tx_data, o_tx_start,
               o_busy, o_done, o_timeout, o_overflow, o_frame_count
    );
endinterface

// File: rtl/debug_frame_collector.sv
// Host-side end of the debug control frame link. Selects one latch
// controller, captures the burst of frames it streams while writing,
// then serializes them MSB-byte-first to the UART transmitter.
module debug_frame_collector #(
    parameter int                    NB_CONTROL_FRAME = 32,
    parameter int                    NB_BYTE          = 8,
    parameter int                    NB_REQUEST       = 6,
    parameter logic [NB_REQUEST-1:0] IDLE_SELECT      = 6'b1111_11,
    parameter int                    MAX_FRAMES       = 4,
    parameter int                    NB_TIMEOUT       = 8,
    parameter int                    TIMEOUT_MAX      = 255
) (
    input logic                     i_clock,
    input logic                     i_reset,
    debug_frame_collector_if.master bus
);

    localparam int BYTES_PER_FRAME = NB_CONTROL_FRAME / NB_BYTE;

    localparam logic [7:0]            LAST_BYTE    = 8'(BYTES_PER_FRAME - 1);
    localparam logic [3:0]            MAX_COUNT    = 4'(MAX_FRAMES);
    localparam logic [NB_TIMEOUT-1:0] TIMEOUT_LAST = NB_TIMEOUT'(TIMEOUT_MAX - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SELECT  = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_SEND    = 2'd3;

    // Buffer is sized for the largest legal depth so a 3-bit index always fits.
    logic [NB_CONTROL_FRAME-1:0] buffer [8];

    logic [1:0]            state;
    logic [NB_REQUEST-1:0] select_q;
    logic [NB_BYTE-1:0]    tx_data_q;
    logic                  tx_start_q;
    logic                  done_q;
    logic                  timeout_q;
    logic                  overflow_q;
    logic [3:0]            frame_count_q;
    logic [NB_TIMEOUT-1:0] timeout_cnt;
    logic [7:0]            byte_idx;
    logic [3:0]            frame_idx;
    logic                  waiting;

    logic                  capture_en;
    logic                  last_byte;
    logic                  last_frame;
    logic [7:0]            nxt_byte_idx;
    logic [3:0]            nxt_frame_idx;
    logic [NB_BYTE-1:0]    cur_byte;
    logic [NB_BYTE-1:0]    nxt_byte;

    // Byte idx of a frame counted from the MSB end.
    function automatic logic [NB_BYTE-1:0] select_byte(
        input logic [NB_CONTROL_FRAME-1:0] frame,
        input logic [7:0]                  idx
    );
        logic [NB_CONTROL_FRAME-1:0] shifted;
        shifted = frame << (int'(idx) * NB_BYTE);
        return shifted[NB_CONTROL_FRAME-1 -: NB_BYTE];
    endfunction

    assign bus.o_request_ready  = (state == ST_IDLE);
    assign bus.o_busy           = (state != ST_IDLE);
    assign bus.o_request_select = select_q;
    assign bus.o_tx_data        = tx_data_q;
    assign bus.o_tx_start       = tx_start_q;
    assign bus.o_done           = done_q;
    assign bus.o_timeout        = timeout_q;
    assign bus.o_overflow       = overflow_q;
    assign bus.o_frame_count    = frame_count_q;

    // A frame is stored on the first writing cycle and on later ones while room remains.
    assign capture_en = bus.i_writing &&
                        ((state == ST_SELECT) ||
                         ((state == ST_CAPTURE) && (frame_count_q != MAX_COUNT)));

    // Current and following byte positions of the serializer.
    always_comb begin
        last_byte     = (byte_idx == LAST_BYTE);
        last_frame    = ((frame_idx + 4'd1) == frame_count_q);
        nxt_byte_idx  = last_byte ? 8'd0 : byte_idx + 8'd1;
        nxt_frame_idx = last_byte ? frame_idx + 4'd1 : frame_idx;
        cur_byte      = select_byte(buffer[frame_idx[2:0]], byte_idx);
        nxt_byte      = select_byte(buffer[nxt_frame_idx[2:0]], nxt_byte_idx);
    end

    // Frame storage; contents are don't-care after reset so it carries none.
    always_ff @(posedge i_clock) begin
        if (capture_en) begin
            buffer[frame_count_q[2:0]] <= bus.i_frame_from_control;
        end
    end

    // Transaction FSM: select, capture, serialize; status pulses default low.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state         <= ST_IDLE;
            select_q      <= IDLE_SELECT;
            tx_data_q     <= '0;
            tx_start_q    <= 1'b0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
            overflow_q    <= 1'b0;
            frame_count_q <= '0;
            timeout_cnt   <= '0;
            byte_idx      <= '0;
            frame_idx     <= '0;
            waiting       <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.i_request_valid) begin
                        select_q      <= bus.i_request_id;
                        frame_count_q <= '0;
                        timeout_cnt   <= '0;
                        overflow_q    <= 1'b0;
                        state         <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (bus.i_writing) begin
                        frame_count_q <= 4'd1;
                        state         <= ST_CAPTURE;
                    end else if (timeout_cnt == TIMEOUT_LAST) begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                        timeout_q   <= 1'b1;
                        select_q    <= IDLE_SELECT;
                        state       <= ST_IDLE;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (bus.i_writing) begin
                        if (frame_count_q == MAX_COUNT) begin
                            overflow_q <= 1'b1;
                        end else begin
                            frame_count_q <= frame_count_q + 4'd1;
                        end
                    end else begin
                        // Releasing select here guarantees an idle gap before the next request.
                        select_q  <= IDLE_SELECT;
                        byte_idx  <= '0;
                        frame_idx <= '0;
                        waiting   <= 1'b0;
                        state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!waiting) begin
                        tx_data_q  <= cur_byte;
                        tx_start_q <= 1'b1;
                        waiting    <= 1'b1;
                    end else if (bus.i_tx_done) begin
                        if (last_byte && last_frame) begin
                            waiting <= 1'b0;
                            done_q  <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            // Next byte starts in the cycle right after the done pulse.
                            byte_idx   <= nxt_byte_idx;
                            frame_idx  <= nxt_frame_idx;
                            tx_data_q  <= nxt_byte;
                            tx_start_q <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_frame_collector.sv
// Directed bench for debug_frame_collector: table of request/frame/byte
// vectors plus sequences for timeout, reset mid-send and back-to-back IDs.
module tb_debug_frame_collector;

    localparam logic [5:0] IDLE_SEL = 6'b111111;

    logic i_clock = 1'b0;
    logic i_reset;

    debug_frame_collector_if dif ();

    debug_frame_collector dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .bus     (dif.master)
    );

    always #5 i_clock = ~i_clock;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [5:0]   id;
        int           sel_wait;
        int           nframes;
        logic [191:0] frames;
        int           nbytes;
        logic [127:0] bytes;
        int           exp_count;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs [5];
    vec_t bb_vec;
    vec_t rst_vec;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Request, stream frames, act as UART for each byte; abort_after>0 returns after that many bytes.
    task automatic run_txn(input vec_t v, input bit hold, input int abort_after);
        int w;
        int gap;
        logic [31:0] fr;
        logic [7:0]  eb;
        check("ready_before", 32'(dif.o_request_ready), 32'd1);
        check("select_before", 32'(dif.o_request_select), 32'(IDLE_SEL));
        dif.i_request_valid = 1'b1;
        dif.i_request_id    = v.id;
        @(posedge i_clock); #1;
        if (!hold) dif.i_request_valid = 1'b0;
        check("busy_accept", 32'(dif.o_busy), 32'd1);
        check("select_id", 32'(dif.o_request_select), 32'(v.id));
        check("ovf_cleared", 32'(dif.o_overflow), 32'd0);
        check("count_cleared", 32'(dif.o_frame_count), 32'd0);
        repeat (v.sel_wait) begin @(posedge i_clock); #1; end
        for (int i = 0; i < v.nframes; i++) begin
            fr = v.frames[191-32*i -: 32];
            dif.i_writing            = 1'b1;
            dif.i_frame_from_control = fr;
            @(posedge i_clock); #1;
            check("select_hold", 32'(dif.o_request_select), 32'(v.id));
        end
        dif.i_writing            = 1'b0;
        dif.i_frame_from_control = '0;
        @(posedge i_clock); #1;
        check("select_release", 32'(dif.o_request_select), 32'(IDLE_SEL));
        check("busy_send", 32'(dif.o_busy), 32'd1);
        for (int k = 0; k < v.nbytes; k++) begin
            eb = v.bytes[127-8*k -: 8];
            w = 0;
            while (dif.o_tx_start !== 1'b1 && w < 8) begin @(posedge i_clock); #1; w++; end
            check("tx_start", 32'(dif.o_tx_start), 32'd1);
            if (k > 0) check("start_after_done", 32'(w), 32'd0);
            check("tx_byte", 32'(dif.o_tx_data), 32'(eb));
            @(posedge i_clock); #1;
            check("start_one_cycle", 32'(dif.o_tx_start), 32'd0);
            gap = k % 3;
            repeat (gap) begin
                @(posedge i_clock); #1;
                check("no_start_waiting", 32'(dif.o_tx_start), 32'd0);
            end
            check("data_held", 32'(dif.o_tx_data), 32'(eb));
            dif.i_tx_done = 1'b1;
            @(posedge i_clock); #1;
            dif.i_tx_done = 1'b0;
            if (k + 1 == abort_after) return;
        end
        check("done_pulse", 32'(dif.o_done), 32'd1);
        check("busy_end", 32'(dif.o_busy), 32'd0);
        check("frame_count", 32'(dif.o_frame_count), 32'(v.exp_count));
        check("overflow", 32'(dif.o_overflow), 32'(v.exp_ovf));
        check("select_end", 32'(dif.o_request_select), 32'(IDLE_SEL));
        if (!hold) begin
            @(posedge i_clock); #1;
            check("done_cleared", 32'(dif.o_done), 32'd0);
            check("no_extra_start", 32'(dif.o_tx_start), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  saw_done;
        bit  saw_start;
        int  starts;

        //          id     wait nfr frames                                                                   nby bytes (first byte leftmost)                          cnt ovf
        vecs[0] = '{6'd2,  0,   1,  {32'hDEADBEEF, 160'h0},                                                   4,  {32'hDEADBEEF, 96'h0},                                 1,  1'b0};
        vecs[1] = '{6'd7,  2,   2,  {32'h01234567, 32'h89ABCDEF, 128'h0},                                     8,  {64'h0123456789ABCDEF, 64'h0},                         2,  1'b0};
        vecs[2] = '{6'd0,  1,   3,  {32'h00000001, 32'h80000000, 32'hFFFFFFFF, 96'h0},                        12, {96'h00000001_80000000_FFFFFFFF, 32'h0},               3,  1'b0};
        vecs[3] = '{6'd62, 3,   4,  {32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C, 32'h4B5A6978, 64'h0},          16, 128'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978,              4,  1'b0};
        vecs[4] = '{6'd9,  0,   5,  {32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00, 32'hCAFEBABE, 32'h0}, 16, 128'h11223344_55667788_99AABBCC_DDEEFF00, 4, 1'b1};
        bb_vec  = '{6'd3,  0,   1,  {32'hA1B2C3D4, 160'h0},                                                   4,  {32'hA1B2C3D4, 96'h0},                                 1,  1'b0};
        rst_vec = '{6'd4,  0,   2,  {32'hCAFEF00D, 32'h12345678, 128'h0},                                     8,  {64'hCAFEF00D12345678, 64'h0},                         2,  1'b0};

        dif.i_request_valid      = 1'b0;
        dif.i_request_id         = '0;
        dif.i_writing            = 1'b0;
        dif.i_frame_from_control = '0;
        dif.i_tx_done            = 1'b0;
        i_reset                  = 1'b1;

        repeat (2) @(posedge i_clock);
        #1;
        check("rst_select", 32'(dif.o_request_select), 32'(IDLE_SEL));
        check("rst_ready", 32'(dif.o_request_ready), 32'd1);
        check("rst_busy", 32'(dif.o_busy), 32'd0);
        check("rst_start", 32'(dif.o_tx_start), 32'd0);
        check("rst_data", 32'(dif.o_tx_data), 32'd0);
        check("rst_done", 32'(dif.o_done), 32'd0);
        check("rst_timeout", 32'(dif.o_timeout), 32'd0);
        check("rst_overflow", 32'(dif.o_overflow), 32'd0);
        check("rst_count", 32'(dif.o_frame_count), 32'd0);
        i_reset = 1'b0;
        @(posedge i_clock); #1;

        // A done pulse with no byte outstanding must do nothing.
        dif.i_tx_done = 1'b1;
        @(posedge i_clock); #1;
        dif.i_tx_done = 1'b0;
        check("stray_done_busy", 32'(dif.o_busy), 32'd0);
        check("stray_done_start", 32'(dif.o_tx_start), 32'd0);
        check("stray_done_done", 32'(dif.o_done), 32'd0);

        for (int i = 0; i < 5; i++) run_txn(vecs[i], 1'b0, 0);

        // Overflow stays set through idle until the next accepted request.
        repeat (3) begin
            @(posedge i_clock); #1;
            check("ovf_sticky", 32'(dif.o_overflow), 32'd1);
        end

        // No response from controller 5: timeout after 255 SELECT cycles.
        dif.i_request_valid = 1'b1;
        dif.i_request_id    = 6'd5;
        @(posedge i_clock); #1;
        dif.i_request_valid = 1'b0;
        check("to_select", 32'(dif.o_request_select), 32'd5);
        check("to_ovf_cleared", 32'(dif.o_overflow), 32'd0);
        n = 0;
        saw_done = 1'b0;
        saw_start = 1'b0;
        while (dif.o_timeout !== 1'b1 && n < 400) begin
            @(posedge i_clock); #1;
            n++;
            if (dif.o_done === 1'b1) saw_done = 1'b1;
            if (dif.o_tx_start === 1'b1) saw_start = 1'b1;
        end
        check("timeout_cycles", 32'(n), 32'd255);
        check("timeout_pulse", 32'(dif.o_timeout), 32'd1);
        check("timeout_select", 32'(dif.o_request_select), 32'(IDLE_SEL));
        check("timeout_busy", 32'(dif.o_busy), 32'd0);
        @(posedge i_clock); #1;
        check("timeout_cleared", 32'(dif.o_timeout), 32'd0);
        check("timeout_no_done", 32'(saw_done), 32'd0);
        check("timeout_no_start", 32'(saw_start), 32'd0);

        // Back-to-back requests to ID 3 with valid held throughout.
        run_txn(bb_vec, 1'b1, 0);
        run_txn(bb_vec, 1'b0, 0);

        // Reset after the second byte of a send.
        run_txn(rst_vec, 1'b0, 2);
        check("third_start_issued", 32'(dif.o_tx_start), 32'd1);
        i_reset = 1'b1;
        #1;
        check("mid_rst_start", 32'(dif.o_tx_start), 32'd0);
        check("mid_rst_select", 32'(dif.o_request_select), 32'(IDLE_SEL));
        check("mid_rst_busy", 32'(dif.o_busy), 32'd0);
        check("mid_rst_data", 32'(dif.o_tx_data), 32'd0);
        @(posedge i_clock); #1;
        i_reset = 1'b0;
        starts = 0;
        repeat (10) begin
            @(posedge i_clock); #1;
            if (dif.o_tx_start === 1'b1) starts++;
        end
        check("mid_rst_no_bytes", 32'(starts), 32'd0);
        run_txn(vecs[0], 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
